// File: rtl/wr_arb_pkg.sv
// Shared constants for the write-port arbiter: memory geometry, mode encodings and the
// source index assignment of the requesting units.
package wr_arb_pkg;

  localparam int unsigned MEM_DEPTH  = 1024;
  localparam int unsigned MEM_WIDTH  = 16;
  localparam int unsigned WORD_WIDTH = 16;

  localparam logic MODE_DIRECTED = 1'b0;
  localparam logic MODE_RR       = 1'b1;

  localparam int unsigned LEARN_COST       = 0;
  localparam int unsigned AM_I_SINK        = 1;
  localparam int unsigned FIX_SINK_LIST    = 2;
  localparam int unsigned NBR_SINK_OTHER   = 3;
  localparam int unsigned FIND_MY_BEST     = 4;
  localparam int unsigned BETTER_NBRS      = 5;
  localparam int unsigned WINNER_POLICY    = 6;
  localparam int unsigned SELECT_MY_ACTION = 7;

endpackage

// File: rtl/wr_port_arbiter_if.sv
// Request/grant and memory write bus between the requesting units and the arbiter.
// master = requester side, slave = arbiter side.
interface wr_port_arbiter_if
  import wr_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned ADDR_W  = $clog2(MEM_DEPTH),
  parameter int unsigned DATA_W  = WORD_WIDTH
);
  localparam int unsigned SEL_W = $clog2(NUM_SRC);

  logic                      mode;
  logic [SEL_W-1:0]          select;
  logic [NUM_SRC-1:0]        req;
  logic [NUM_SRC*ADDR_W-1:0] src_addr;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        gnt;
  logic                      mem_wr_en;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_data;

  modport master (
    output mode, select, req, src_addr, src_data,
    input  gnt, mem_wr_en, mem_addr, mem_data
  );

  modport slave (
    input  mode, select, req, src_addr, src_data,
    output gnt, mem_wr_en, mem_addr, mem_data
  );

endinterface

// File: rtl/wr_port_arbiter_rr_pick.sv
// Combinational rotating-priority finder: first asserted request strictly after ptr,
// wrapping modulo NUM_SRC.
module rr_pick #(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0]         req,
  input  logic [$clog2(NUM_SRC)-1:0] ptr,
  output logic [NUM_SRC-1:0]         onehot,
  output logic                       valid,
  output logic [$clog2(NUM_SRC)-1:0] idx
);
  localparam int unsigned SEL_W = $clog2(NUM_SRC);

  always_comb begin
    onehot = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int unsigned off = 1; off <= NUM_SRC; off++) begin
      int unsigned cand;
      cand = (32'(ptr) + off) % NUM_SRC;
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = SEL_W'(cand);
      end
    end
  end

endmodule

// File: rtl/wr_port_arbiter.sv
// Single write-port arbiter: directed or round-robin grant, one-cycle registered memory write.
// Optional denied-request counter enabled by WR_ARB_DENY_CNT_EN.
module wr_port_arbiter
  import wr_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned ADDR_W  = $clog2(MEM_DEPTH),
  parameter int unsigned DATA_W  = WORD_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  wr_port_arbiter_if.slave   bus
`ifdef WR_ARB_DENY_CNT_EN
  ,
  output logic [15:0]        deny_cnt
`endif
);
  localparam int unsigned SEL_W = $clog2(NUM_SRC);

  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [NUM_SRC-1:0] rr_onehot;
  logic               rr_valid;
  logic [SEL_W-1:0]   rr_idx;

  logic [NUM_SRC-1:0] gnt_vec;
  logic               gnt_any;
  logic [SEL_W-1:0]   gnt_idx;

  logic               wr_en_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_q;

  rr_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_rr_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .onehot (rr_onehot),
    .valid  (rr_valid),
    .idx    (rr_idx)
  );

  always_comb begin
    gnt_vec = '0;
    gnt_any = 1'b0;
    gnt_idx = ptr_q;
    if (!rst) begin
      if (bus.mode == MODE_RR) begin
        gnt_vec = rr_onehot;
        gnt_any = rr_valid;
        gnt_idx = rr_idx;
      end else if (32'(bus.select) < NUM_SRC && bus.req[bus.select]) begin
        gnt_vec[bus.select] = 1'b1;
        gnt_any             = 1'b1;
        gnt_idx             = bus.select;
      end
    end
  end

  // Pointer follows the winner in either mode so a later round-robin pass resumes after it.
  assign ptr_d = gnt_any ? gnt_idx : ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      ptr_q   <= SEL_W'(NUM_SRC - 1);
    end else begin
      wr_en_q <= gnt_any;
      ptr_q   <= ptr_d;
      if (gnt_any) begin
        addr_q <= bus.src_addr[gnt_idx*ADDR_W +: ADDR_W];
        data_q <= bus.src_data[gnt_idx*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.gnt       = gnt_vec;
  assign bus.mem_wr_en = wr_en_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_data  = data_q;

`ifdef WR_ARB_DENY_CNT_EN
  logic [15:0] deny_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      deny_q <= '0;
    end else if (|bus.req && !gnt_any && deny_q != 16'hFFFF) begin
      deny_q <= deny_q + 16'd1;
    end
  end

  assign deny_cnt = deny_q;
`endif

endmodule

// File: doc/wr_port_arbiter.md
WR_PORT_ARBITER -- requirements
Module: wr_port_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 8, number of requesting units (legal 2..16).
REQ-002 Parameter ADDR_W, default 10, memory address width (MEM_DEPTH 1024).
REQ-003 Parameter DATA_W, default 16, write word width (WORD_WIDTH).
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port mode  input  1  0 = directed (select-driven), 1 = round-robin.
REQ-007 Port select  input  SEL_W=$clog2(NUM_SRC)  source index used in directed mode.
REQ-008 Port req  input  NUM_SRC  per-source write request.
REQ-009 Port src_addr  input  NUM_SRC*ADDR_W  packed addresses, source i at slice [i*ADDR_W +: ADDR_W].
REQ-010 Port src_data  input  NUM_SRC*DATA_W  packed write data, same packing.
REQ-011 Port gnt  output  NUM_SRC  one-hot-or-zero grant, combinational in the request cycle.
REQ-012 Port mem_wr_en  output  1  registered memory write enable.
REQ-013 Port mem_addr  output  ADDR_W  registered memory address.
REQ-014 Port mem_data  output  DATA_W  registered memory write data.
REQ-015 Port deny_cnt  output  16  denied-request cycle count; present only with WR_ARB_DENY_CNT_EN.

Function
REQ-016 At most one gnt bit high per cycle; gnt[i] high only when req[i] high.
REQ-017 Directed mode: gnt[select]=req[select]; all other grants 0; select >= NUM_SRC yields no grant.
REQ-018 Round-robin mode: search starts at ptr+1 modulo NUM_SRC, wraps, grants first asserted req.
REQ-019 ptr updates to the granted index only on a cycle with a grant, in either mode; otherwise holds.
REQ-020 Latency exactly one cycle: grant to source i in cycle t drives mem_wr_en=1, mem_addr/mem_data = source i's cycle-t values in cycle t+1.
REQ-021 No grant in cycle t: mem_wr_en=0 in t+1; mem_addr/mem_data hold previous values.
REQ-022 Requester holds req, addr, data until it sees gnt; denied requests are not queued internally.
REQ-023 Mode and select changes take effect in the cycle they are applied; ptr survives mode changes.
REQ-024 Back-to-back grants allowed every cycle; same source may win consecutive cycles only when it is the sole requester (round-robin) or selected (directed).

Reset
REQ-025 rst high at a clock edge: mem_wr_en=0, mem_addr=0, mem_data=0, ptr=NUM_SRC-1, deny_cnt=0.
REQ-026 gnt forced to 0 while rst is high; a write in flight when rst asserts is dropped.
REQ-027 First round-robin search after reset starts at source 0.

Configuration
REQ-028 Macro WR_ARB_DENY_CNT_EN defined: deny_cnt increments by 1 each cycle where any req bit is high and not granted; saturates at 16'hFFFF.
REQ-029 Macro undefined: deny_cnt port and counter logic absent; all other behaviour identical.

Structure
REQ-030 Package wr_arb_pkg holds MEM_DEPTH, MEM_WIDTH, WORD_WIDTH, mode constants (MODE_DIRECTED=0, MODE_RR=1) and source indices (LEARN_COST=0, AM_I_SINK=1, FIX_SINK_LIST=2, NBR_SINK_OTHER=3, FIND_MY_BEST=4, BETTER_NBRS=5, WINNER_POLICY=6, SELECT_MY_ACTION=7).
REQ-031 Sub-module rr_pick (combinational rotating priority finder: req vector, ptr -> one-hot, valid, index) instantiated once.

Verification
REQ-032 Directed, select=3, req=8'b0000_1010, src_addr[3]=10'h155, src_data[3]=16'hBEEF -> gnt=8'h08; next cycle mem_wr_en=1, mem_addr=10'h155, mem_data=16'hBEEF.
REQ-033 Round-robin after reset, req=8'hFF held 9 cycles -> grants to sources 0,1,...,7,0 in order, mem_wr_en=1 every cycle from the second.
REQ-034 Round-robin, ptr=6, req=8'b0100_0001 -> gnt=8'h01 (wrap), then next cycle gnt=8'h40.
REQ-035 Directed, select=5, req=8'b0000_0001 for 4 cycles -> gnt=0, mem_wr_en=0 throughout; with WR_ARB_DENY_CNT_EN, deny_cnt=4.
REQ-036 rst asserted the cycle after a grant -> mem_wr_en=0, mem_addr=0, mem_data=0 next cycle; next round-robin grant goes to lowest requesting index.
REQ-037 NUM_SRC=5, directed, select=6, req=5'h1F -> no grant; round-robin wraps 4 -> 0.
